gray_codec_pipe: RTL and testbench
==================================

Name: gray_codec_pipe

Overview:
Parametrised, pipelined binary/Gray code converter with a valid/ready handshake. It supports both directions, selected per transaction by a mode bit. It is the successor to the fixed 10-bit combinational binary-to-Gray encoder. It sits between counter/pointer logic and clock-domain-crossing or position-sensor interfaces, so one instance serves encode and decode paths with full backpressure.

Parameters:
WIDTH, 10, data width in bits; legal range 2..64.
STAGES, 2, pipeline register stages, which is also the latency; legal range 1..WIDTH.

Ports:
clk        input   1      rising-edge clock
rst_n      input   1      asynchronous active-low reset
in_valid   input   1      input beat valid
in_ready   output  1      block can accept an input beat
in_mode    input   1      0 = binary->Gray encode, 1 = Gray->binary decode
in_data    input   WIDTH  operand
out_valid  output  1      result valid
out_ready  input   1      downstream accepts result
out_mode   output  1      mode of the beat being presented
out_data   output  WIDTH  result
busy       output  1      any pipeline stage holds a valid beat

Behaviour:
- Reset (async assert, sync release): all stage valid bits clear; out_valid=0, out_data=0, out_mode=0, busy=0. in_ready=1 from the first clock after release.
- Encode: gray[WIDTH-1] = bin[WIDTH-1]; for i < WIDTH-1, gray[i] = bin[i+1] ^ bin[i]. Every bit is a pure function of the input; no constants are forced.
- Decode: bin[WIDTH-1] = gray[WIDTH-1]; bin[i] = bin[i+1] ^ gray[i], i.e. the XOR prefix from the MSB.
- Decode is split across stages. Bits are divided MSB-first into STAGES chunks of ceil(WIDTH/STAGES) bits; the last chunk may be short. Stage s resolves chunk s and carries the running prefix bit forward. Encode data passes through the same stages so both modes have identical latency.
- Each stage holds {valid, mode, partial data, prefix bit}.
- Handshake:
  - A transfer occurs when valid&ready are both high on a clock edge.
  - Stage k loads when (!valid[k] || stage k+1 advancing); the last stage advances on out_ready.
  - Bubbles collapse, so no empty stage blocks the pipe.
  - in_ready = stage-0 load condition, combinational from out_ready through the stage valid bits only.
- Latency: exactly STAGES cycles from an input transfer to out_valid with out_ready held high. Throughput is 1 beat/cycle.
- Backpressure: while out_valid && !out_ready, out_data and out_mode are held stable. A full pipe deasserts in_ready in the same cycle.
- Simultaneous events: with a full pipe and out_ready=1, output retire and input accept occur in the same cycle, with no bubble.
- Order: beats exit in strict input order. Mixed modes may be interleaved beat by beat.
- Reset mid-operation: all in-flight beats are discarded with no partial output. in_data is ignored while in_valid=0.
- busy = OR of the stage valid bits.

Optional Feature:
GRAY_CODEC_PARITY_EN
- Defined:
  - Adds output out_parity (1 bit), the even parity of out_data, registered alongside it.
  - Adds input in_parity_chk (1 bit) and output par_err (1 bit, sticky).
  - In decode mode, if the XOR of in_data differs from in_parity_chk, par_err sets when that beat exits.
  - par_err clears only on reset.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package gray_codec_pkg holds:
  - mode enum (MODE_ENC=1'b0, MODE_DEC=1'b1)
  - function chunk_lo(stage, WIDTH, STAGES)
  - function bin2gray(), used by the bench model
  - function gray2bin(), used by the bench model
- One natural sub-module, gray_codec_stage: holds one register stage with its load/advance logic and the chunk-resolve XOR. It is instantiated STAGES times via generate.

Test Plan:
- Encode sweep, WIDTH=10, STAGES=2:
  - in_data 0..1023 back-to-back with out_ready=1 -> outputs match bin2gray, 1 per cycle after 2-cycle latency.
  - Specifically check 10'h002 -> 10'h003, 10'h3FF -> 10'h200, 10'h000 -> 10'h000.
- Decode round trip: feed each encode result back with mode=1 -> original value recovered for all 1024 codes; 10'h200 -> 10'h3FF.
- Backpressure:
  - Random out_ready (50%) with mixed modes -> no loss, no duplication, order preserved.
  - out_data stable while stalled.
  - in_ready=0 exactly when both stages are full and out_ready=0.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight -> out_valid=0 and busy=0 immediately (asynchronously); no stale beat after release.
- Parameter corners:
  - WIDTH=2, STAGES=1: 2'b10 encode -> 2'b11.
  - WIDTH=64, STAGES=64: 64'h8000_0000_0000_0000 decode -> all ones after 64 cycles.
- Parity (with GRAY_CODEC_PARITY_EN):
  - Decode beat 10'h003 with in_parity_chk=1 -> par_err=1, which stays set.
  - out_parity matches the XOR of out_data on every beat.

Source files
------------

// File: rtl/gray_codec_pkg.sv
// rtl/gray_codec_pkg.sv - shared types, chunk geometry and reference Gray conversions
package gray_codec_pkg;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  function automatic int chunk_size(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  // Chunks are taken MSB-first; trailing stages may get an empty chunk (hi < lo).
  function automatic int chunk_hi(input int stage, input int width, input int stages);
    return width - 1 - stage * chunk_size(width, stages);
  endfunction

  function automatic int chunk_lo(input int stage, input int width, input int stages);
    int lo;
    lo = width - (stage + 1) * chunk_size(width, stages);
    return (lo < 0) ? 0 : lo;
  endfunction

  function automatic logic [63:0] bin2gray(input logic [63:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [63:0] gray2bin(input logic [63:0] g);
    logic [63:0] b;
    b[63] = g[63];
    for (int i = 62; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// rtl/gray_codec_stage.sv - one pipeline register stage: load/advance control and chunk-resolve XOR
// Optional sideband under GRAY_CODEC_PARITY_EN carries the per-beat parity error flag.
module gray_codec_stage
  import gray_codec_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int STAGES = 2,
  parameter int IDX    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid_i,
  input  logic             up_mode_i,
  input  logic [WIDTH-1:0] up_data_i,
`ifdef GRAY_CODEC_PARITY_EN
  input  logic             up_perr_i,
  output logic             perr_o,
`endif
  input  logic             dn_ready_i,
  output logic             valid_o,
  output logic             mode_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int HI = chunk_hi(IDX, WIDTH, STAGES);
  localparam int LO = chunk_lo(IDX, WIDTH, STAGES);

  logic             valid_q, valid_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] res_data;
  logic             prefix;
  logic             load;

  // The running prefix is the lowest binary bit already resolved upstream.
  if (IDX == 0 || HI < 0) begin : g_prefix_zero
    assign prefix = 1'b0;
  end else begin : g_prefix_carry
    assign prefix = up_data_i[HI+1];
  end

  always_comb begin
    logic pre;
    res_data = up_data_i;
    pre      = prefix;
    if (IDX == 0 && up_mode_i == MODE_ENC) begin
      res_data = up_data_i ^ (up_data_i >> 1);
    end
    if (up_mode_i == MODE_DEC) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (i <= HI && i >= LO) begin
          pre         = pre ^ up_data_i[i];
          res_data[i] = pre;
        end
      end
    end
  end

  assign load = !valid_q || dn_ready_i;

  always_comb begin
    valid_d = valid_q;
    mode_d  = mode_q;
    data_d  = data_q;
    if (load) begin
      valid_d = up_valid_i;
      if (up_valid_i) begin
        mode_d = up_mode_i;
        data_d = res_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
    end
  end

`ifdef GRAY_CODEC_PARITY_EN
  logic perr_q, perr_d;

  always_comb begin
    perr_d = perr_q;
    if (load && up_valid_i) begin
      perr_d = up_perr_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign perr_o = perr_q;
`endif

  assign valid_o = valid_q;
  assign mode_o  = mode_q;
  assign data_o  = data_q;

endmodule

// File: rtl/gray_codec_pipe.sv
// rtl/gray_codec_pipe.sv - pipelined binary/Gray encode/decode with valid/ready backpressure
// Optional parity check/report ports are enabled by defining GRAY_CODEC_PARITY_EN.
module gray_codec_pipe
  import gray_codec_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data,
`ifdef GRAY_CODEC_PARITY_EN
  input  logic             in_parity_chk,
  output logic             out_parity,
  output logic             par_err,
`endif
  output logic             busy
);

  // Index 0 is the input port; index k+1 is the output of stage k.
  logic [STAGES:0] v_w;
  logic [STAGES:0] m_w;
  logic [WIDTH-1:0] d_w [STAGES+1];
  logic [STAGES:0] rdy;

  assign v_w[0] = in_valid;
  assign m_w[0] = in_mode;
  assign d_w[0] = in_data;

  // rdy[k] is the load condition of stage k; it collapses bubbles back to the input.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !v_w[k+1] || rdy[k+1];
    end
  end

`ifdef GRAY_CODEC_PARITY_EN
  logic [STAGES:0] e_w;
  logic            par_err_q, par_err_d;

  assign e_w[0] = (in_mode == MODE_DEC) && ((^in_data) != in_parity_chk);
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    gray_codec_stage #(
      .WIDTH (WIDTH),
      .STAGES(STAGES),
      .IDX   (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .up_valid_i(v_w[k]),
      .up_mode_i (m_w[k]),
      .up_data_i (d_w[k]),
`ifdef GRAY_CODEC_PARITY_EN
      .up_perr_i (e_w[k]),
      .perr_o    (e_w[k+1]),
`endif
      .dn_ready_i(rdy[k+1]),
      .valid_o   (v_w[k+1]),
      .mode_o    (m_w[k+1]),
      .data_o    (d_w[k+1])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_w[STAGES];
  assign out_mode  = m_w[STAGES];
  assign out_data  = d_w[STAGES];
  assign busy      = |v_w[STAGES:1];

`ifdef GRAY_CODEC_PARITY_EN
  always_comb begin
    par_err_d = par_err_q;
    if (out_valid && out_ready && e_w[STAGES]) begin
      par_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err    = par_err_q;
  assign out_parity = ^out_data;
`endif

endmodule

// File: tb/tb_gray_codec_pipe.sv
// tb/tb_gray_codec_pipe.sv - self-checking bench for gray_codec_pipe (main and parameter-corner instances)
module tb_gray_codec_pipe;
  import gray_codec_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, in_mode, out_valid, out_ready, out_mode, busy;
  logic [9:0] in_data, out_data;
  logic       c2_valid, c2_in_ready, c2_mode, c2_out_valid, c2_out_ready, c2_out_mode, c2_busy;
  logic [1:0] c2_data, c2_out_data;
  logic        c64_valid, c64_in_ready, c64_mode, c64_out_valid, c64_out_ready, c64_out_mode, c64_busy;
  logic [63:0] c64_data, c64_out_data;
`ifdef GRAY_CODEC_PARITY_EN
  logic in_parity_chk, out_parity, par_err;
  logic c2_pchk, c2_opar, c2_perr, c64_pchk, c64_opar, c64_perr;
`endif

  gray_codec_pipe #(.WIDTH(10), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
    .out_data(out_data),
`ifdef GRAY_CODEC_PARITY_EN
    .in_parity_chk(in_parity_chk), .out_parity(out_parity), .par_err(par_err),
`endif
    .busy(busy)
  );

  gray_codec_pipe #(.WIDTH(2), .STAGES(1)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(c2_valid), .in_ready(c2_in_ready), .in_mode(c2_mode),
    .in_data(c2_data), .out_valid(c2_out_valid), .out_ready(c2_out_ready), .out_mode(c2_out_mode),
    .out_data(c2_out_data),
`ifdef GRAY_CODEC_PARITY_EN
    .in_parity_chk(c2_pchk), .out_parity(c2_opar), .par_err(c2_perr),
`endif
    .busy(c2_busy)
  );

  gray_codec_pipe #(.WIDTH(64), .STAGES(64)) dut_c64 (
    .clk(clk), .rst_n(rst_n), .in_valid(c64_valid), .in_ready(c64_in_ready), .in_mode(c64_mode),
    .in_data(c64_data), .out_valid(c64_out_valid), .out_ready(c64_out_ready), .out_mode(c64_out_mode),
    .out_data(c64_out_data),
`ifdef GRAY_CODEC_PARITY_EN
    .in_parity_chk(c64_pchk), .out_parity(c64_opar), .par_err(c64_perr),
`endif
    .busy(c64_busy)
  );

  int checks = 0;
  int errors = 0;
  int occ = 0;

  typedef struct packed {
    logic       m;
    logic [9:0] d;
  } beat_t;

  typedef struct {
    logic       mode;
    logic [9:0] din;
    logic [9:0] dout;
  } vec_t;

  beat_t in_q[$];
  beat_t exp_q[$];
  vec_t  tbl[9];

  function automatic logic [9:0] enc10(input logic [9:0] x);
    logic [63:0] t;
    t = bin2gray(64'(x));
    return t[9:0];
  endfunction

  function automatic logic [9:0] dec10(input logic [9:0] x);
    logic [63:0] t;
    t = gray2bin(64'(x));
    return t[9:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_stream(input string name, input int rdy_pct, output int cyc);
    int got, idx;
    logic held_v;
    logic [10:0] held;
    cyc = 0; got = 0; idx = 0; held_v = 1'b0; held = '0;
    while ((idx < in_q.size() || got < exp_q.size()) && cyc < 5000) begin
      @(negedge clk);
      if (idx < in_q.size()) begin
        in_valid = 1'b1;
        in_mode  = in_q[idx].m;
        in_data  = in_q[idx].d;
      end else begin
        in_valid = 1'b0;
        in_mode  = 1'($urandom_range(1));
        in_data  = 10'($urandom);
      end
`ifdef GRAY_CODEC_PARITY_EN
      in_parity_chk = ^in_data;
`endif
      out_ready = (int'($urandom_range(99)) < rdy_pct);
      #1;
      if (held_v) chk({name, " hold"}, 64'({out_valid, out_mode, out_data}), 64'({1'b1, held}));
      chk({name, " in_ready"}, 64'(in_ready), 64'(!(occ == 2 && !out_ready)));
      if (out_valid && out_ready) begin
        if (got < exp_q.size()) chk({name, " data"}, 64'({out_mode, out_data}), 64'(exp_q[got]));
        else chk({name, " extra beat"}, 64'(got + 1), 64'(exp_q.size()));
`ifdef GRAY_CODEC_PARITY_EN
        chk({name, " out_parity"}, 64'(out_parity), 64'(^out_data));
`endif
        got++;
      end
      held_v = out_valid && !out_ready;
      held   = {out_mode, out_data};
      occ    = occ + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    chk({name, " done"}, 64'(got), 64'(exp_q.size()));
    in_q.delete();
    exp_q.delete();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    int cyc, n;
    logic stale;
    logic [9:0] r;
    logic m;

    tbl[0] = '{1'b0, 10'h002, 10'h003};
    tbl[1] = '{1'b0, 10'h3FF, 10'h200};
    tbl[2] = '{1'b0, 10'h000, 10'h000};
    tbl[3] = '{1'b1, 10'h200, 10'h3FF};
    tbl[4] = '{1'b0, 10'h155, 10'h1FF};
    tbl[5] = '{1'b1, 10'h1FF, 10'h155};
    tbl[6] = '{1'b1, 10'h003, 10'h002};
    tbl[7] = '{1'b0, 10'h2AA, 10'h3FF};
    tbl[8] = '{1'b1, 10'h3FF, 10'h2AA};

    in_valid = 0; in_mode = 0; in_data = '0; out_ready = 0;
    c2_valid = 0; c2_mode = 0; c2_data = '0; c2_out_ready = 0;
    c64_valid = 0; c64_mode = 0; c64_data = '0; c64_out_ready = 0;
`ifdef GRAY_CODEC_PARITY_EN
    in_parity_chk = 0; c2_pchk = 0; c64_pchk = 0;
`endif

    repeat (2) @(negedge clk);
    #1;
    chk("reset out_valid/busy", 64'({out_valid, busy}), 64'(0));
    chk("reset out_data/mode", 64'({out_mode, out_data}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("in_ready after reset", 64'(in_ready), 64'(1));

    // Single beat latency
    @(negedge clk);
    in_valid = 1; in_mode = 0; in_data = 10'h002; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    #1;
    chk("latency 1 cycle not valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    #1;
    chk("latency 2 cycles valid", 64'({out_valid, out_mode, out_data}), 64'({1'b1, 1'b0, 10'h003}));
    @(negedge clk);
    out_ready = 0;

    foreach (tbl[i]) begin
      in_q.push_back({tbl[i].mode, tbl[i].din});
      exp_q.push_back({tbl[i].mode, tbl[i].dout});
    end
    run_stream("table", 100, cyc);
    chk("table cycles", 64'(cyc), 64'(11));

    for (int i = 0; i < 1024; i++) begin
      in_q.push_back({1'b0, 10'(i)});
      exp_q.push_back({1'b0, enc10(10'(i))});
    end
    run_stream("encode sweep", 100, cyc);
    chk("encode sweep cycles", 64'(cyc), 64'(1026));

    for (int i = 0; i < 1024; i++) begin
      in_q.push_back({1'b1, enc10(10'(i))});
      exp_q.push_back({1'b1, 10'(i)});
    end
    run_stream("decode roundtrip", 100, cyc);

    for (int i = 0; i < 300; i++) begin
      r = 10'($urandom);
      m = 1'($urandom_range(1));
      in_q.push_back({m, r});
      exp_q.push_back({m, m ? dec10(r) : enc10(r)});
    end
    run_stream("backpressure mixed", 50, cyc);

    // Reset with two beats in flight
    @(negedge clk);
    in_valid = 1; in_mode = 0; in_data = 10'h155; out_ready = 0;
    @(negedge clk);
    in_data = 10'h2AA;
    @(negedge clk);
    in_valid = 0;
    #1;
    chk("pipe full before reset", 64'({busy, out_valid, in_ready}), 64'(3'b110));
    #2;
    rst_n = 0;
    #1;
    chk("async reset clears", 64'({out_valid, busy}), 64'(0));
    @(negedge clk);
    rst_n = 1; out_ready = 1; occ = 0;
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      stale = stale | out_valid | busy;
    end
    chk("no stale beat after reset", 64'(stale), 64'(0));
    out_ready = 0;

    // WIDTH=2, STAGES=1
    @(negedge clk);
    c2_valid = 1; c2_mode = 0; c2_data = 2'b10; c2_out_ready = 1;
    #1;
    chk("w2 in_ready", 64'(c2_in_ready), 64'(1));
    @(negedge clk);
    c2_valid = 0;
    #1;
    chk("w2 encode", 64'({c2_out_valid, c2_out_mode, c2_out_data}), 64'({1'b1, 1'b0, 2'b11}));

    // WIDTH=64, STAGES=64
    @(negedge clk);
    c64_valid = 1; c64_mode = 1; c64_data = 64'h8000_0000_0000_0000; c64_out_ready = 1;
    n = 0;
    do begin
      @(negedge clk);
      c64_valid = 0;
      #1;
      n++;
    end while (!c64_out_valid && n < 200);
    chk("w64 latency", 64'(n), 64'(64));
    chk("w64 decode", c64_out_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("w64 mode", 64'(c64_out_mode), 64'(1));

`ifdef GRAY_CODEC_PARITY_EN
    #1;
    chk("par_err clear", 64'(par_err), 64'(0));
    @(negedge clk);
    in_valid = 1; in_mode = 1; in_data = 10'h003; in_parity_chk = 1; out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    #1;
    chk("par beat held", 64'({out_valid, out_data, par_err}), 64'({1'b1, 10'h002, 1'b0}));
    chk("par out_parity", 64'(out_parity), 64'(1));
    out_ready = 1;
    @(negedge clk);
    #1;
    chk("par_err set", 64'(par_err), 64'(1));
    in_valid = 1; in_mode = 0; in_data = 10'h005; in_parity_chk = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (4) @(negedge clk);
    #1;
    chk("par_err sticky", 64'(par_err), 64'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
